// File: rtl/taylor_sched_pkg.sv
// Shared constants, state type and helpers for the taylor core scheduler.
package taylor_sched_pkg;

  localparam int N_CORES_DEF = 34;
  localparam int DW_DEF      = 28;
  localparam int STAGGER_DEF = 10;

  typedef enum logic [0:0] {
    SEQ = 1'b0,
    RUN = 1'b1
  } sched_state_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/taylor_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// searching upward and wrapping from N-1 back to 0.
module taylor_rr_pick
  import taylor_sched_pkg::*;
#(
  parameter int N  = N_CORES_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  // Walk from farthest to nearest so the closest requester is written last.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign o_gnt[gi] = o_any && (o_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/taylor_core_sched.sv
// Staggered reset release plus round-robin output arbitration for the core bank.
// Optional TAYLOR_SCHED_STATS_EN adds a saturating transfer counter port xfer_cnt.
module taylor_core_sched
  import taylor_sched_pkg::*;
#(
  parameter  int N_CORES = N_CORES_DEF,
  parameter  int DW      = DW_DEF,
  parameter  int STAGGER = STAGGER_DEF,
  localparam int IDW     = idx_w(N_CORES)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [N_CORES-1:0]    core_rst,
  input  logic [N_CORES-1:0]    core_vld,
  input  logic [N_CORES*DW-1:0] core_data,
  output logic [N_CORES-1:0]    core_ack,
  output logic [DW-1:0]         out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  seq_done
`ifdef TAYLOR_SCHED_STATS_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam int            CW          = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [CW-1:0] STAG_RELOAD = CW'(STAGGER - 1);
  localparam logic [0:0]    ST_SEQ      = SEQ;
  localparam logic [0:0]    ST_RUN      = RUN;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [IDW-1:0]     r_rel_idx;
  logic [N_CORES-1:0] r_core_rst;
  logic               r_seq_done;
  logic [IDW-1:0]     r_ptr;
  logic [DW-1:0]      r_out_data;
  logic [IDW-1:0]     r_out_id;
  logic               r_out_vld;

  logic [N_CORES-1:0] w_elig;
  logic [N_CORES-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_any;
  logic               w_load;
  logic [DW-1:0]      w_sel_data;

  assign w_elig     = core_vld & ~r_core_rst;
  assign w_load     = ~r_out_vld | out_rdy;
  assign w_sel_data = core_data[w_gnt_idx*DW +: DW];

  taylor_rr_pick #(
    .N  (N_CORES),
    .IW (IDW)
  ) u_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // A grant during rst would be dropped by the register clear, so never ack it.
  assign core_ack = (w_load && !rst) ? w_gnt : '0;

  // Release one core whenever the countdown reaches zero; leave SEQ once none remain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SEQ;
      r_cnt      <= '0;
      r_rel_idx  <= '0;
      r_core_rst <= '1;
      r_seq_done <= 1'b0;
    end else if (r_state == ST_SEQ) begin
      if (r_core_rst == '0) begin
        r_state    <= ST_RUN;
        r_seq_done <= 1'b1;
      end else if (r_cnt == '0) begin
        r_core_rst[r_rel_idx] <= 1'b0;
        r_rel_idx             <= r_rel_idx + 1'b1;
        r_cnt                 <= STAG_RELOAD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= IDW'(N_CORES - 1);
      r_out_data <= '0;
      r_out_id   <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_data <= w_sel_data;
        r_out_id   <= w_gnt_idx;
        r_out_vld  <= 1'b1;
        r_ptr      <= w_gnt_idx;
      end else begin
        r_out_vld  <= 1'b0;
      end
    end
  end

`ifdef TAYLOR_SCHED_STATS_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (r_out_vld && out_rdy && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

  assign core_rst = r_core_rst;
  assign seq_done = r_seq_done;
  assign out_data = r_out_data;
  assign out_id   = r_out_id;
  assign out_vld  = r_out_vld;

endmodule

// File: tb/tb_taylor_core_sched.sv
// Bench for taylor_core_sched: hand vector table, directed corner sequences and a
// randomized run checked against a cycle-level behavioural model of the scheduler.
module tb_taylor_core_sched;
  import taylor_sched_pkg::*;

  localparam int N       = 34;
  localparam int DW      = 28;
  localparam int STAGGER = 10;
  localparam int IDW     = $clog2(N);
  localparam int T_LAST  = 1 + (N - 1) * STAGGER;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      core_rst;
  logic [N-1:0]      core_vld;
  logic [N*DW-1:0]   core_data;
  logic [N-1:0]      core_ack;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              out_vld;
  logic              out_rdy;
  logic              seq_done;
`ifdef TAYLOR_SCHED_STATS_EN
  logic [15:0]       xfer_cnt;
`endif
  logic [DW-1:0]     c_data [N];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign core_data[gi*DW +: DW] = c_data[gi];
    end
  endgenerate

  taylor_core_sched #(.N_CORES(N), .DW(DW), .STAGGER(STAGGER)) dut (
    .clk       (clk),
    .rst       (rst),
    .core_rst  (core_rst),
    .core_vld  (core_vld),
    .core_data (core_data),
    .core_ack  (core_ack),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .seq_done  (seq_done)
`ifdef TAYLOR_SCHED_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edges since reset release, last winner, output slot.
  int          m_cyc  = 0;
  int          m_ptr  = N - 1;
  bit          m_ovld = 1'b0;
  logic [DW-1:0] m_odata = '0;
  int          m_oid  = 0;
  int          m_xfer = 0;
  int          m_grant = -1;
  logic [N-1:0] last_ack;
  logic [N-1:0] last_rst;

  function automatic bit released(input int i);
    return m_cyc >= 1 + i * STAGGER;
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return DW'(i * 4099 + 17);
  endfunction

  function automatic logic [63:0] bits(input int a, input int b, input int c);
    logic [63:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic tick(input bit verbose);
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  exp_rst;
    logic [DW-1:0] gdata;
    bit            load;
    bit            xfer;
    int            j;
    #1;
    load    = !m_ovld || out_rdy;
    m_grant = -1;
    if (!rst && load) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (core_vld[j] && released(j)) begin
          m_grant = j;
          break;
        end
      end
    end
    exp_ack = '0;
    if (m_grant >= 0) exp_ack[m_grant] = 1'b1;
    last_ack = core_ack;
    last_rst = core_rst;
    chk("core_ack", 64'(core_ack), 64'(exp_ack));
    gdata = (m_grant >= 0) ? c_data[m_grant] : '0;
    xfer  = m_ovld && out_rdy;
    if (verbose && xfer) $display("xfer: id=%0d data=%0h", m_oid, m_odata);
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_ptr = N - 1; m_ovld = 1'b0; m_odata = '0; m_oid = 0; m_xfer = 0;
    end else begin
      if (xfer && m_xfer < 65535) m_xfer++;
      if (m_cyc < 1000000) m_cyc++;
      if (load) begin
        if (m_grant >= 0) begin
          m_ovld = 1'b1; m_odata = gdata; m_oid = m_grant; m_ptr = m_grant;
        end else begin
          m_ovld = 1'b0;
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) exp_rst[i] = !released(i);
    chk("core_rst", 64'(core_rst), 64'(exp_rst));
    chk("seq_done", 64'(seq_done), 64'(m_cyc >= T_LAST + 1));
    chk("out_vld", 64'(out_vld), 64'(m_ovld));
    chk("out_data", 64'(out_data), 64'(m_odata));
    chk("out_id", 64'(out_id), 64'(m_oid));
`ifdef TAYLOR_SCHED_STATS_EN
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_xfer));
`endif
  endtask

  typedef struct {
    logic [63:0] vld;
    bit          rdy;
    int          ack;
    bit          ovld;
    int          oid;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           t_rst_last;
    int           t_done;
    int           found;
    logic [N-1:0] all1;
    logic [N-1:0] exp_oh;

    // Table starts with pointer at core 0 and an empty output register.
    tbl[0]  = '{bits(2, 7, 33), 1'b1, 2,  1'b1, 2};
    tbl[1]  = '{bits(2, 7, 33), 1'b1, 7,  1'b1, 7};
    tbl[2]  = '{bits(2, 7, 33), 1'b1, 33, 1'b1, 33};
    tbl[3]  = '{bits(2, 7, 33), 1'b1, 2,  1'b1, 2};
    tbl[4]  = '{bits(2, 7, 33), 1'b1, 7,  1'b1, 7};
    tbl[5]  = '{bits(3, 9, -1), 1'b0, -1, 1'b1, 7};
    tbl[6]  = '{bits(3, 9, -1), 1'b0, -1, 1'b1, 7};
    tbl[7]  = '{bits(3, 9, -1), 1'b0, -1, 1'b1, 7};
    tbl[8]  = '{bits(3, 9, -1), 1'b0, -1, 1'b1, 7};
    tbl[9]  = '{bits(3, 9, -1), 1'b1, 9,  1'b1, 9};
    tbl[10] = '{bits(3, -1, -1), 1'b1, 3, 1'b1, 3};
    tbl[11] = '{64'd0,           1'b1, -1, 1'b0, 0};
    tbl[12] = '{bits(5, -1, -1), 1'b0, 5, 1'b1, 5};
    tbl[13] = '{bits(5, -1, -1), 1'b0, -1, 1'b1, 5};
    tbl[14] = '{bits(5, -1, -1), 1'b1, 5, 1'b1, 5};
    tbl[15] = '{bits(0, -1, -1), 1'b1, 0, 1'b1, 0};
    tbl[16] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 1'b1, 1};
    tbl[17] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 1'b1, 2};
    tbl[18] = '{64'd0,           1'b1, -1, 1'b0, 0};
    tbl[19] = '{64'd0,           1'b0, -1, 1'b0, 0};

    all1 = '1;
    for (int i = 0; i < N; i++) c_data[i] = data_of(i);
    rst = 1'b1; core_vld = '0; out_rdy = 1'b1;
    repeat (5) tick(1'b0);

    // Reset release timing, with every core requesting around cycle 15.
    rst = 1'b0;
    t_rst_last = -1; t_done = -1;
    for (int c = 1; c <= 340; c++) begin
      core_vld = (c >= 15 && c <= 19) ? all1 : '0;
      tick(1'b0);
      if (c >= 15 && c <= 19) begin
        chk("mask_ack_hi", 64'(last_ack[N-1:2]), 64'd0);
        chk("mask_ack_any", 64'(|last_ack), 64'd1);
        chk("mask_ack_in_rst", 64'(last_ack & last_rst), 64'd0);
      end
      if (c == 1)  chk("rst0_clear_c1", 64'(core_rst[0]), 64'd0);
      if (c == 50) chk("rst5_held_c50", 64'(core_rst[5]), 64'd1);
      if (!core_rst[N-1] && t_rst_last < 0) t_rst_last = c;
      if (seq_done && t_done < 0) t_done = c;
    end
    chk("rst33_cycle", 64'(t_rst_last), 64'd331);
    chk("seq_done_cycle", 64'(t_done), 64'd332);

    // Round-robin, backpressure, single requester and drain vectors.
    for (int v = 0; v < 20; v++) begin
      core_vld = tbl[v].vld[N-1:0];
      out_rdy  = tbl[v].rdy;
      tick(1'b1);
      exp_oh = '0;
      if (tbl[v].ack >= 0) exp_oh[tbl[v].ack] = 1'b1;
      $display("vec %0d: ack=%0h out_vld=%0b out_id=%0d", v, last_ack, out_vld, out_id);
      chk("tbl_ack", 64'(last_ack), 64'(exp_oh));
      chk("tbl_out_vld", 64'(out_vld), 64'(tbl[v].ovld));
      if (tbl[v].ovld) begin
        chk("tbl_out_id", 64'(out_id), 64'(tbl[v].oid));
        chk("tbl_out_data", 64'(out_data), 64'(data_of(tbl[v].oid)));
      end
    end

    // Reset pulse with a sample pending: dropped, sequence restarts at core 0.
    core_vld = bits(4, -1, -1); out_rdy = 1'b0;
    tick(1'b0);
    chk("pre_rst_out_vld", 64'(out_vld), 64'd1);
    rst = 1'b1; core_vld = all1;
    tick(1'b0);
    $display("mid-run reset: out_vld=%0b core_rst=%0h", out_vld, core_rst);
    chk("midrst_out_vld", 64'(out_vld), 64'd0);
    chk("midrst_core_rst", 64'(core_rst), 64'(all1));
    rst = 1'b0; out_rdy = 1'b1;
    found = -1;
    for (int c = 0; c < 20 && found < 0; c++) begin
      tick(1'b0);
      for (int i = 0; i < N; i++) if (last_ack[i]) found = i;
    end
    chk("first_grant_after_rst", 64'(found), 64'd0);

    // Randomized traffic honouring the core contract, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      tick(1'b0);
      for (int i = 0; i < N; i++) begin
        if (m_grant == i) begin
          if ($urandom_range(0, 1) == 1) c_data[i] = DW'($urandom);
          else core_vld[i] = 1'b0;
        end else if (!core_vld[i] && $urandom_range(0, 3) == 0) begin
          core_vld[i] = 1'b1;
          c_data[i]   = DW'($urandom);
        end
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;

`ifdef TAYLOR_SCHED_STATS_EN
    rst = 1'b1; tick(1'b0); rst = 1'b0;
    core_vld = bits(0, -1, -1); out_rdy = 1'b1;
    repeat (65600) tick(1'b0);
    chk("xfer_sat", 64'(xfer_cnt), 64'hFFFF);
    repeat (5) tick(1'b0);
    chk("xfer_sat_hold", 64'(xfer_cnt), 64'hFFFF);
    rst = 1'b1; tick(1'b0); rst = 1'b0;
    chk("xfer_rst", 64'(xfer_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
